// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl: zero-init sweep then round-robin A/B arbitration of the register file write port
// Ports: clk/reset (async, active-high); init_req re-runs the zero sweep from RUN;
//   a_*/b_* valid/reg/data in, ready out (combinational grant);
//   write_reg/write_data/reg_write drive the register file; init_done high while running.
module regfile_write_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_req,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              reg_write,
  output logic              init_done
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic reg_write_q, reg_write_d, init_done_q, init_done_d;
  logic ptr_q, ptr_d;
  logic run;
  logic [ADDR_W-1:0] g_reg;
  // ptr_q = 0 gives A the tie, 1 gives B the tie; init_req blocks both grants
  assign run = state_q == RUN && !init_req;
  assign a_ready = run && a_valid && (!b_valid || !ptr_q);
  assign b_ready = run && b_valid && (!a_valid || ptr_q);
  assign g_reg = a_ready ? a_reg : b_reg;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    write_reg_d = write_reg_q;
    write_data_d = write_data_q;
    reg_write_d = 1'b0;
    init_done_d = 1'b0;
    if (state_q == INIT) begin
      reg_write_d = 1'b1;
      write_reg_d = cnt_q;
      write_data_d = '0;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
        state_d = RUN;
        cnt_d = '0;
      end
    end else if (init_req) begin
      state_d = INIT;
      cnt_d = '0;
    end else begin
      init_done_d = 1'b1;
      if (a_ready || b_ready) begin
        write_reg_d = g_reg;
        write_data_d = a_ready ? a_data : b_data;
        // r0 is hardwired zero: accept the write but never enable it
        reg_write_d = g_reg != '0;
        ptr_d = a_ready;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q <= '0;
      ptr_q <= 1'b0;
      write_reg_q <= '0;
      write_data_q <= '0;
      reg_write_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      write_reg_q <= write_reg_d;
      write_data_q <= write_data_d;
      reg_write_q <= reg_write_d;
      init_done_q <= init_done_d;
    end
  end
  assign write_reg = write_reg_q;
  assign write_data = write_data_q;
  assign reg_write = reg_write_q;
  assign init_done = init_done_q;
endmodule

// File: tb/tb_regfile_write_ctrl.sv
// tb_regfile_write_ctrl: directed and randomized checks of regfile_write_ctrl against a behavioural model
module tb_regfile_write_ctrl;
  logic clk = 0, reset = 0, init_req = 0, a_valid = 0, b_valid = 0;
  logic [4:0] a_reg = 0, b_reg = 0, write_reg;
  logic [31:0] a_data = 0, b_data = 0, write_data;
  logic a_ready, b_ready, reg_write, init_done;
  int errors = 0, checks = 0;
  bit chk_en = 0;
  logic [31:0] rf [32];
  logic [31:0] mrf [32];
  bit m_run, m_turn_b;
  int m_pos;
  logic e_we, e_done;
  logic [4:0] e_reg;
  logic [31:0] e_data;
  logic exp_a, exp_b;
  bit acc_a, acc_b;

  regfile_write_ctrl dut (
    .clk(clk), .reset(reset), .init_req(init_req),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // register file as the real one sees the port: no reset, commits on the edge after presentation
  always @(posedge clk) if (reg_write) rf[write_reg] <= write_data;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  assign exp_a = m_run && !init_req && a_valid && (!b_valid || !m_turn_b);
  assign exp_b = m_run && !init_req && b_valid && (!a_valid || m_turn_b);

  always @(posedge clk or posedge reset) begin
    bit ga, gb;
    ga = exp_a;
    gb = exp_b;
    if (reset) begin
      m_run = 0; m_pos = 0; m_turn_b = 0;
      e_we = 0; e_reg = 0; e_data = 0; e_done = 0;
    end else if (!m_run) begin
      e_we = 1; e_reg = 5'(m_pos); e_data = 0; e_done = 0;
      m_pos++;
      if (m_pos == 32) begin
        m_run = 1; m_pos = 0;
        for (int i = 0; i < 32; i++) mrf[i] = 0;
      end
    end else if (init_req) begin
      e_we = 0; e_done = 0; m_run = 0; m_pos = 0;
    end else begin
      e_done = 1;
      e_we = 0;
      if (ga || gb) begin
        e_reg = ga ? a_reg : b_reg;
        e_data = ga ? a_data : b_data;
        e_we = e_reg != 0;
        if (e_reg != 0) mrf[e_reg] = e_data;
        m_turn_b = ga;
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("reg_write", 32'(reg_write), 32'(e_we));
    chk("write_reg", 32'(write_reg), 32'(e_reg));
    chk("write_data", write_data, e_data);
    chk("init_done", 32'(init_done), 32'(e_done));
    chk("a_ready", 32'(a_ready), 32'(exp_a));
    chk("b_ready", 32'(b_ready), 32'(exp_b));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1;
    #2 chk_en = 1;
    chk("rst_reg_write", 32'(reg_write), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_write_reg", 32'(write_reg), 0);
    #9 reset = 0;
    for (int i = 1; i <= 32; i++) begin
      step();
      chk("sweep_reg", 32'(write_reg), 32'(i - 1));
      chk("sweep_we", 32'(reg_write), 1);
    end
    chk("done_early", 32'(init_done), 0);
    step();
    chk("done_edge33", 32'(init_done), 1);
    // single requester
    a_valid = 1; a_reg = 5; a_data = 32'hDEADBEEF;
    #1 chk("single_ready", 32'(a_ready), 1);
    step();
    a_valid = 0;
    chk("single_we", 32'(reg_write), 1);
    chk("single_reg", 32'(write_reg), 5);
    chk("single_data", write_data, 32'hDEADBEEF);
    step();
    chk("single_we_off", 32'(reg_write), 0);
    // a B write hands the tie back to A before the contention run
    b_valid = 1; b_reg = 6; b_data = 32'h66;
    step();
    b_valid = 0;
    step();
    a_valid = 1; a_reg = 1; a_data = 32'h11;
    b_valid = 1; b_reg = 3; b_data = 32'h33;
    step();
    chk("cont_r1", 32'(write_reg), 1);
    a_reg = 2; a_data = 32'h22;
    step();
    chk("cont_r3", 32'(write_reg), 3);
    chk("cont_we3", 32'(reg_write), 1);
    b_reg = 4; b_data = 32'h44;
    step();
    chk("cont_r2", 32'(write_reg), 2);
    chk("cont_we2", 32'(reg_write), 1);
    a_valid = 0;
    step();
    chk("cont_r4", 32'(write_reg), 4);
    chk("cont_data4", write_data, 32'h44);
    b_valid = 0;
    // r0 write
    step();
    b_valid = 1; b_reg = 0; b_data = 32'h1234;
    #1 chk("r0_ready", 32'(b_ready), 1);
    step();
    b_valid = 0;
    chk("r0_we", 32'(reg_write), 0);
    step();
    step();
    chk("r0_read", rf[0], 0);
    chk("rf_r4", rf[4], 32'h44);
    // re-init while A waits
    a_valid = 1; a_reg = 9; a_data = 32'h99; init_req = 1;
    #1 chk("reinit_ready", 32'(a_ready), 0);
    step();
    init_req = 0;
    chk("reinit_done", 32'(init_done), 0);
    chk("reinit_we", 32'(reg_write), 0);
    for (int i = 1; i <= 32; i++) begin
      step();
      chk("resweep_reg", 32'(write_reg), 32'(i - 1));
      if (i < 32) chk("resweep_ready", 32'(a_ready), 0);
    end
    chk("resweep_ready_end", 32'(a_ready), 1);
    step();
    a_valid = 0;
    chk("reinit_done_back", 32'(init_done), 1);
    chk("reinit_a_reg", 32'(write_reg), 9);
    chk("reinit_a_data", write_data, 32'h99);
    // async reset between edges during a transfer
    a_valid = 1; a_reg = 10; a_data = 32'hAA;
    step();
    a_reg = 11; a_data = 32'hBB;
    chk("pre_rst_we", 32'(reg_write), 1);
    #2 reset = 1;
    #1;
    chk("arst_we", 32'(reg_write), 0);
    chk("arst_done", 32'(init_done), 0);
    chk("arst_a_ready", 32'(a_ready), 0);
    chk("arst_b_ready", 32'(b_ready), 0);
    reset = 0;
    a_valid = 0;
    step();
    chk("arst_sweep0_reg", 32'(write_reg), 0);
    chk("arst_sweep0_we", 32'(reg_write), 1);
    repeat (32) step();
    chk("arst_done_back", 32'(init_done), 1);
    // randomized traffic honouring the hold-until-ready rule
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      step();
      init_req = $urandom_range(0, 149) == 0;
      if (!a_valid || acc_a) begin
        a_valid = $urandom_range(0, 2) != 0; a_reg = 5'($urandom); a_data = $urandom;
      end
      if (!b_valid || acc_b) begin
        b_valid = $urandom_range(0, 2) != 0; b_reg = 5'($urandom); b_data = $urandom;
      end
      if ($urandom_range(0, 999) == 0) begin
        reset = 1;
        #2 reset = 0;
      end
    end
    a_valid = 0; b_valid = 0; init_req = 0;
    for (int k = 0; k < 40 && !m_run; k++) step();
    repeat (3) step();
    for (int i = 0; i < 32; i++) chk("rf_final", rf[i], mrf[i]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
